// File: rtl/trace_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : trace_unpacker
//  Description : Consumer end of the trace-debug tagged-word stream. Pops
//                {tag, payload} words from the trace FIFO and rebuilds a clean
//                sample stream with an absolute sample index and a gap flag
//                and gap size on the first sample after upstream loss. Also
//                keeps a saturating total-drop statistic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock
//    rst            in   synchronous active-high reset
//    fifo_data      in   {tag, payload}; tag=1 is a drop marker whose low
//                        counter_width_p bits hold the number of lost samples
//    fifo_valid     in   FIFO word available
//    fifo_ready     out  word consumed when fifo_valid & fifo_ready
//    out_data       out  reconstructed sample
//    out_valid      out  output register holds a sample
//    out_ready      in   downstream accepts (transfer on out_valid & out_ready)
//    out_index      out  absolute index of out_data, counting dropped samples
//    out_gap        out  samples were lost immediately before out_data
//    out_gap_count  out  number lost before out_data (saturating), 0 if no gap
//    drop_total     out  saturating sum of marker counts since reset/clear
//    drop_total_clr in   synchronous clear of drop_total
//    bad_marker     out  one-cycle pulse when a zero-count marker is accepted
// ============================================================================
module trace_unpacker #(
    parameter int sample_width_p  = 16,
    parameter int counter_width_p = 16,
    parameter int index_width_p   = 32,
    parameter int total_width_p   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [sample_width_p:0]    fifo_data,
    input  logic                       fifo_valid,
    output logic                       fifo_ready,
    output logic [sample_width_p-1:0]  out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [index_width_p-1:0]   out_index,
    output logic                       out_gap,
    output logic [counter_width_p-1:0] out_gap_count,
    output logic [total_width_p-1:0]   drop_total,
    input  logic                       drop_total_clr,
    output logic                       bad_marker
);

    typedef enum logic [0:0] {
        NO_GAP      = 1'b0,
        GAP_PENDING = 1'b1
    } state_e;

    localparam int c_gap_sum_w   = counter_width_p + 1;
    localparam int c_total_sum_w = total_width_p + 1;

    state_e                       state_q, state_d;
    logic [sample_width_p-1:0]    out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic [index_width_p-1:0]     out_index_q, out_index_d;
    logic                         out_gap_q, out_gap_d;
    logic [counter_width_p-1:0]   out_gap_count_q, out_gap_count_d;
    logic [total_width_p-1:0]     drop_total_q, drop_total_d;
    logic                         bad_marker_q, bad_marker_d;
    logic [index_width_p-1:0]     next_idx_q, next_idx_d;
    logic [counter_width_p-1:0]   gap_acc_q, gap_acc_d;

    logic                         w_accept;
    logic                         w_is_marker;
    logic [counter_width_p-1:0]   w_cnt;
    logic [c_gap_sum_w-1:0]       w_gap_sum;
    logic [total_width_p-1:0]     w_total_base;
    logic [c_total_sum_w-1:0]     w_total_sum;

    // The output register can take a new word whenever it is empty or being
    // drained this cycle; markers never occupy it but use the same handshake.
    assign fifo_ready  = ~out_valid_q | out_ready;
    assign w_accept    = fifo_valid & fifo_ready;
    assign w_is_marker = fifo_data[sample_width_p];
    assign w_cnt       = fifo_data[counter_width_p-1:0];

    // One extra bit on each sum exposes the carry used for saturation.
    assign w_gap_sum    = {1'b0, gap_acc_q} + {1'b0, w_cnt};
    // A clear in the same cycle as a marker restarts the total from zero
    // before the marker count is added.
    assign w_total_base = drop_total_clr ? '0 : drop_total_q;
    assign w_total_sum  = c_total_sum_w'(w_total_base) + c_total_sum_w'(w_cnt);

    always_comb begin
        state_d         = state_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        out_index_d     = out_index_q;
        out_gap_d       = out_gap_q;
        out_gap_count_d = out_gap_count_q;
        drop_total_d    = w_total_base;
        bad_marker_d    = 1'b0;
        next_idx_d      = next_idx_q;
        gap_acc_d       = gap_acc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (!w_is_marker) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_data[sample_width_p-1:0];
                out_index_d = next_idx_q;
                next_idx_d  = next_idx_q + 1'b1;
                if (state_q == GAP_PENDING) begin
                    out_gap_d       = 1'b1;
                    out_gap_count_d = gap_acc_q;
                end else begin
                    out_gap_d       = 1'b0;
                    out_gap_count_d = '0;
                end
                gap_acc_d = '0;
                state_d   = NO_GAP;
            end else if (w_cnt == '0) begin
                bad_marker_d = 1'b1;
            end else begin
                next_idx_d = next_idx_q + index_width_p'(w_cnt);
                gap_acc_d  = w_gap_sum[counter_width_p] ? '1
                                                        : w_gap_sum[counter_width_p-1:0];
                drop_total_d = w_total_sum[total_width_p] ? '1
                                                          : w_total_sum[total_width_p-1:0];
                state_d = GAP_PENDING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= NO_GAP;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_index_q     <= '0;
            out_gap_q       <= 1'b0;
            out_gap_count_q <= '0;
            drop_total_q    <= '0;
            bad_marker_q    <= 1'b0;
            next_idx_q      <= '0;
            gap_acc_q       <= '0;
        end else begin
            state_q         <= state_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_index_q     <= out_index_d;
            out_gap_q       <= out_gap_d;
            out_gap_count_q <= out_gap_count_d;
            drop_total_q    <= drop_total_d;
            bad_marker_q    <= bad_marker_d;
            next_idx_q      <= next_idx_d;
            gap_acc_q       <= gap_acc_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign out_gap       = out_gap_q;
    assign out_gap_count = out_gap_count_q;
    assign drop_total    = drop_total_q;
    assign bad_marker    = bad_marker_q;

endmodule
`default_nettype wire
